// File: rtl/lsu_rmw.sv
// lsu_rmw -- load/store unit, initiator side of a word-only data memory port.
//
// Turns RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
// The memory has no byte enables, so SB/SH are done as read-modify-write:
// read the word in ACCESS, write the merged word in WRITE.
//
// Handshake: a request is accepted on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE, so at most one request is in flight and
// there is no back-to-back acceptance. Completion is a one-cycle resp_valid
// pulse; resp_rdata/resp_err are meaningful only while resp_valid is high.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_store           1=store, 0=load
//   req_funct3          RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr            byte address
//   req_wdata           store data (low bytes used for B/H)
//   resp_valid          completion pulse
//   resp_rdata          extended load data, 0 for stores and errors
//   resp_err            misaligned or illegal funct3
//   mem_addr            word-aligned address to memory
//   mem_wdata/mem_write word write port
//   mem_rdata           combinational read data for mem_addr
//   load_cnt/store_cnt/err_cnt  event counters (only with LSU_PERF_CNT_EN)
//   dbg_state           current FSM state for observation
//
// Optional feature macro: LSU_PERF_CNT_EN.

module lsu_rmw #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef LSU_PERF_CNT_EN
    output logic [31:0]       load_cnt,
    output logic [31:0]       store_cnt,
    output logic [31:0]       err_cnt,
`endif
    output logic [1:0]        dbg_state
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rdata_q;

    logic              req_illegal;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic              is_sw;

    // Decode of an incoming request: misalignment or unsupported funct3.
    always_comb begin
        req_illegal = 1'b0;
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
            req_illegal = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
            req_illegal = 1'b1;
        if (req_store) begin
            if (req_funct3 != F3_B && req_funct3 != F3_H && req_funct3 != F3_W)
                req_illegal = 1'b1;
        end else begin
            if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
                req_illegal = 1'b1;
        end
    end

    // Little-endian lane selection from the word currently on mem_rdata.
    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_ext = {24'h0, lane_b};
            F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_ext = {16'h0, lane_h};
            F3_W:    load_ext = mem_rdata;
            default: load_ext = '0;
        endcase
    end

    // Replace the target byte/half of the captured word with store data.
    always_comb begin
        merged = merge_q;
        if (f3_q == F3_B)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0] = wdata_q[15:0];
    end

    assign is_sw = store_q && (f3_q == F3_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_illegal;
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!store_q)
                        rdata_q <= load_ext;
                    else
                        merge_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Next state and outputs. Memory-side outputs depend only on registered
    // state, so req_* changes cannot glitch them; mem_write is additionally
    // gated by rst so a reset in the write cycle drops the write.
    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wdata  = '0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_n = req_illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                if (!store_q) begin
                    state_n = RESP;
                end else if (is_sw) begin
                    mem_wdata = wdata_q;
                    mem_write = ~rst;
                    state_n   = RESP;
                end else begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                mem_wdata = merged;
                mem_write = ~rst;
                state_n   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign resp_rdata = rdata_q;
    assign resp_err   = (state == RESP) && err_q;
    assign dbg_state  = state;

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else if (state == RESP) begin
            if (err_q)
                err_cnt <= err_cnt + 32'd1;
            else if (store_q)
                store_cnt <= store_cnt + 32'd1;
            else
                load_cnt <= load_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// Testbench for lsu_rmw: directed cases plus randomized requests checked by a
// scoreboard against a word-array reference model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt, store_cnt, err_cnt;
`endif

  lsu_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata),
`ifdef LSU_PERF_CNT_EN
    .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory (environment) ----------------
  // 16 words, aliased by addr[5:2]; high addresses (wrap region) map here too.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass = 0;
  int acc_cyc = 0;
  int wr_seen = 0;
  int mdl_load = 0, mdl_store = 0, mdl_err = 0;

  // Expected response: {err, rdata[31:0], latency[1:0], write_count[1:0]}
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Computes the response from the RV32I rules and updates ref_mem.
  function automatic logic [36:0] model(input logic st, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, bv, hv, r;
    int sh, hs;
    bit bad;
    w  = ref_mem[a[5:2]];
    sh = 8 * int'(a[1:0]);
    hs = a[1] ? 16 : 0;
    bad = 0;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) bad = 1;
    if (f3 == 3'd2 && a[1:0] != 2'd0) bad = 1;
    if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1;
    if (st && f3 > 3'd2) bad = 1;
    if (bad) return {1'b1, 32'd0, 2'd1, 2'd0};
    if (!st) begin
      bv = (w >> sh) & 32'hFF;
      hv = (w >> hs) & 32'hFFFF;
      case (f3)
        3'd0: r = (bv >= 128) ? bv - 32'd256 : bv;
        3'd1: r = (hv >= 32768) ? hv - 32'd65536 : hv;
        3'd2: r = w;
        3'd4: r = bv;
        default: r = hv;
      endcase
      return {1'b0, r, 2'd2, 2'd0};
    end
    case (f3)
      3'd0: begin
        ref_mem[a[5:2]] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        return {1'b0, 32'd0, 2'd3, 2'd1};
      end
      3'd1: begin
        ref_mem[a[5:2]] = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
        return {1'b0, 32'd0, 2'd3, 2'd1};
      end
      default: begin
        ref_mem[a[5:2]] = wd;
        return {1'b0, 32'd0, 2'd2, 2'd1};
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit scored);
    logic [36:0] e;
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    if (scored) begin
      e = model(st, f3, a, wd);
      exp_q.push_back(e);
      if (e[36]) mdl_err++;
      else if (st) mdl_store++;
      else mdl_load++;
    end
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    acc_cyc    = cyc;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_store  = $urandom_range(0, 1);
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [36:0] e;
    bit same;
    if (rst) begin
      wr_seen = 0;
    end else if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e[36]});
        chk("resp_rdata", resp_rdata, e[35:4]);
        chk("latency", 32'(cyc - acc_cyc), {30'd0, e[3:2]});
        chk("write_count", 32'(wr_seen), {30'd0, e[1:0]});
        same = 1;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) same = 0;
        chk("mem_contents", {31'd0, same}, 32'd1);
      end
      wr_seen = 0;
    end else if (mem_write) begin
      wr_seen++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_state_idle", {30'd0, dbg_state}, 32'd0);

    // Directed: loads from word 0x8899AABB at 0x10
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 1);
    issue(1'b0, 3'b001, 32'h10, 32'h0, 1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1);
    // Sub-word and word stores
    issue(1'b1, 3'b001, 32'h10, 32'h0000CAFE, 1);
    issue(1'b1, 3'b000, 32'h12, 32'h12345655, 1);
    issue(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 1);
    issue(1'b0, 3'b010, 32'h14, 32'h0, 1);
    // Errors
    issue(1'b1, 3'b001, 32'h11, 32'h1234, 1);
    issue(1'b0, 3'b010, 32'h12, 32'h0, 1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1);
    issue(1'b1, 3'b100, 32'h10, 32'h0, 1);
    // Wrap-around region
    issue(1'b1, 3'b000, 32'hFFFFFFFF, 32'h000000A5, 1);
    issue(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 1);
    issue(1'b0, 3'b101, 32'hFFFFFFFE, 32'h0, 1);

    // Reset during the WRITE cycle of an SB: the write must be dropped.
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    issue(1'b1, 3'b000, 32'h19, 32'h000000EE, 0);
    @(negedge clk);                         // ACCESS
    @(negedge clk);                         // WRITE
    chk("rmw_write_cycle", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drops_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_idle", {30'd0, dbg_state}, 32'd0);
    chk("post_rst_mem_unchanged", mem[6], ref_mem[6]);
    chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
`ifdef LSU_PERF_CNT_EN
    mdl_load = 0; mdl_store = 0; mdl_err = 0;
`endif

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      a = {($urandom_range(0, 3) == 0) ? 26'h3FFFFFF : 26'h0,
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef LSU_PERF_CNT_EN
    chk("load_cnt", load_cnt, 32'(mdl_load));
    chk("store_cnt", store_cnt, 32'(mdl_store));
    chk("err_cnt", err_cnt, 32'(mdl_err));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
